// File: rtl/divide_issue_ctrl.sv
// Issue/writeback sequencer between the decode pipeline and a multi-cycle divide unit.
// Latches one divide op, starts the unit, waits for its result and holds it for writeback.
module divide_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    // pipeline side
    input  logic        div_req,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_rem,
    input  logic        op_signed,
    input  logic [4:0]  op_rd,
    input  logic        op_wen,
    input  logic        flush,
    output logic        div_ack,
    output logic        stall,
    // divide-unit side
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        start_div,
    output logic        div_type,
    output logic        is_signed_div,
    output logic [4:0]  reg_rd,
    output logic        wen,
    input  logic [31:0] wdata_du,
    input  logic        busy_du,
    input  logic        done_du,
    input  logic [4:0]  reg_rd_du,
    input  logic        wen_du,
    // writeback side
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    input  logic        wb_ack,
    output logic        err_timeout
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 7;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              rem;
        logic              sgn;
        logic [REG_W-1:0]  rd;
        logic              wen;
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    div_op_t           op_q;
    logic [DATA_W-1:0] res_q;
    logic [REG_W-1:0]  res_rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept_c;
    logic              cap_c;
    logic              err_set_c;
    logic              cnt_last_c;

    // Acceptance is gated by reset so no handshake completes while nRST is low
    assign accept_c   = (state == IDLE) & div_req & ~flush & ~busy_du & nRST;
    assign div_ack    = accept_c;
    assign cnt_last_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; in WAIT a flush outranks the timeout
    always_comb begin
        state_nxt = state;
        cap_c     = 1'b0;
        err_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (done_du) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        cap_c     = 1'b1;
                        state_nxt = (wen_du && (reg_rd_du != '0)) ? HOLD : IDLE;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end else if (cnt_last_c) begin
                    err_set_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (flush || wb_ack) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (done_du) begin
                    state_nxt = IDLE;
                end else if (cnt_last_c) begin
                    err_set_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control outputs registered from the next state so they line up with the state they decode
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            start_div   <= 1'b0;
            stall       <= 1'b0;
            wb_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            start_div   <= (state_nxt == START);
            stall       <= (state_nxt != IDLE);
            wb_valid    <= (state_nxt == HOLD);
            err_timeout <= err_set_c;
        end
    end

    // Wait counter: cleared on entry to WAIT/DRAIN, counts while there
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if ((state_nxt == WAIT) || (state_nxt == DRAIN)) begin
            if (state_nxt != state) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Operand capture on acceptance; stays put for the whole operation
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_q <= '0;
        end else if (accept_c) begin
            op_q <= {op_a, op_b, op_rem, op_signed, op_rd, op_wen};
        end
    end

    // Result capture; only written in WAIT so it is stable throughout HOLD
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res_q    <= '0;
            res_rd_q <= '0;
        end else if (cap_c) begin
            res_q    <= wdata_du;
            res_rd_q <= reg_rd_du;
        end
    end

    assign rs1_data      = op_q.a;
    assign rs2_data      = op_q.b;
    assign div_type      = op_q.rem;
    assign is_signed_div = op_q.sgn;
    assign reg_rd        = op_q.rd;
    assign wen           = op_q.wen;
    assign wb_data       = res_q;
    assign wb_rd         = res_rd_q;

endmodule

// File: tb/tb_divide_issue_ctrl.sv
// Self-checking bench for divide_issue_ctrl: directed vector table, hand sequences
// and randomized operations checked against an event-timing reference model.
module tb_divide_issue_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        div_req, op_rem, op_signed, op_wen, flush;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        div_ack, stall;
    logic [31:0] rs1_data, rs2_data;
    logic        start_div, div_type, is_signed_div, wen;
    logic [4:0]  reg_rd;
    logic [31:0] wdata_du;
    logic        busy_du, done_du, wen_du;
    logic [4:0]  reg_rd_du;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_ack, err_timeout;

    int total = 0;
    int bad   = 0;
    bit pending_err = 1'b0;

    divide_issue_ctrl #(.TIMEOUT(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .div_req(div_req), .op_a(op_a), .op_b(op_b), .op_rem(op_rem),
        .op_signed(op_signed), .op_rd(op_rd), .op_wen(op_wen), .flush(flush),
        .div_ack(div_ack), .stall(stall),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .start_div(start_div),
        .div_type(div_type), .is_signed_div(is_signed_div), .reg_rd(reg_rd), .wen(wen),
        .wdata_du(wdata_du), .busy_du(busy_du), .done_du(done_du),
        .reg_rd_du(reg_rd_du), .wen_du(wen_du),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_ack(wb_ack),
        .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    // One operation: stimulus plus expected outcome (cycle 0 = acceptance cycle)
    typedef struct {
        logic [31:0] a, b;
        bit          rem, sgn, wen;
        logic [4:0]  rd;
        int          lat, fl, ackd;
        logic [4:0]  ret_rd;
        bit          ret_wen;
        bit          has_wb;
        int          wb_first, wb_last, idle;
        bit          err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input bit rem,
                                input bit sgn, input logic [4:0] rd, input int lat, input int fl,
                                input int ackd, input logic [4:0] rr, input bit rw, input bit hw,
                                input int wf, input int wl, input int idle, input bit err,
                                input logic [31:0] data);
        vec_t v;
        v.a = a; v.b = b; v.rem = rem; v.sgn = sgn; v.rd = rd; v.wen = 1'b1;
        v.lat = lat; v.fl = fl; v.ackd = ackd; v.ret_rd = rr; v.ret_wen = rw;
        v.has_wb = hw; v.wb_first = wf; v.wb_last = wl; v.idle = idle; v.err = err;
        v.data = data;
        return v;
    endfunction

    // Divide-unit behaviour: RISC-V style truncating quotient/remainder
    function automatic logic [31:0] div_ref(input vec_t v);
        logic signed [31:0] sa, sb;
        sa = v.a;
        sb = v.b;
        if (v.sgn) return v.rem ? 32'(sa % sb) : 32'(sa / sb);
        return v.rem ? (v.a % v.b) : (v.a / v.b);
    endfunction

    // Reference model: resolve the operation's fate from event times.
    // done at D=1+lat; WAIT starts at cycle 2; 64 waiting cycles allowed per WAIT/DRAIN visit.
    function automatic vec_t model(input vec_t s);
        vec_t v;
        int d, ds, k, e;
        v = s;
        d = 1 + s.lat;
        v.has_wb = 1'b0; v.wb_first = 0; v.wb_last = 0; v.err = 1'b0;
        v.data = div_ref(s);
        if (s.fl != 0 && s.fl < d && s.fl <= 65) begin
            ds = (s.fl == 1) ? 2 : s.fl + 1;
            if (d - ds <= 63) v.idle = d + 1;
            else begin v.err = 1'b1; v.idle = ds + 64; end
        end else if (s.fl != 0 && s.fl == d && d <= 65) begin
            v.idle = d + 1;
        end else if (d > 65) begin
            v.err = 1'b1; v.idle = 66;
        end else if (s.ret_wen && s.ret_rd != 5'd0) begin
            k = d + 1 + s.ackd;
            e = (s.fl != 0 && s.fl > d && s.fl < k) ? s.fl : k;
            v.has_wb = 1'b1; v.wb_first = d + 1; v.wb_last = e; v.idle = e + 1;
        end else begin
            v.idle = d + 1;
        end
        return v;
    endfunction

    // Drive one operation cycle by cycle; the idle cycle is checked by the next caller
    task automatic run_vec(input vec_t v);
        int  d;
        bit  in_hold, exp_wb;
        d = 1 + v.lat;
        for (int c = 0; c < v.idle; c++) begin
            in_hold   = v.has_wb && c >= v.wb_first;
            exp_wb    = in_hold && c <= v.wb_last;
            div_req   = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            op_a      = (c == 0) ? v.a : $urandom;
            op_b      = (c == 0) ? v.b : $urandom;
            op_rem    = (c == 0) ? v.rem : 1'($urandom);
            op_signed = (c == 0) ? v.sgn : 1'($urandom);
            op_rd     = (c == 0) ? v.rd : 5'($urandom);
            op_wen    = (c == 0) ? v.wen : 1'($urandom);
            flush     = (v.fl != 0 && c == v.fl);
            busy_du   = (c >= 1 && c < d);
            done_du   = (c == d) ? 1'b1 : ((c == 1 || in_hold) ? 1'($urandom) : 1'b0);
            wdata_du  = (c == d) ? div_ref(v) : $urandom;
            reg_rd_du = (c == d) ? v.ret_rd : 5'($urandom);
            wen_du    = (c == d) ? v.ret_wen : 1'($urandom);
            wb_ack    = in_hold ? (c == v.wb_first + v.ackd) : 1'($urandom);
            @(negedge CLK);
            check("div_ack", 32'(div_ack), 32'(c == 0));
            check("start_div", 32'(start_div), 32'(c == 1));
            check("stall", 32'(stall), 32'(c != 0));
            check("wb_valid", 32'(wb_valid), 32'(exp_wb));
            check("err_timeout", 32'(err_timeout), 32'((c == 0) && pending_err));
            if (c >= 1) begin
                check("rs1_data", rs1_data, v.a);
                check("rs2_data", rs2_data, v.b);
                check("op_ctl", 32'({div_type, is_signed_div, reg_rd, wen}),
                      32'({v.rem, v.sgn, v.rd, v.wen}));
            end
            if (exp_wb) begin
                check("wb_data", wb_data, v.data);
                check("wb_rd", 32'(wb_rd), 32'(v.ret_rd));
            end
            @(posedge CLK);
            #1;
        end
        pending_err = v.err;
    endtask

    task automatic idle_check(input string tag);
        div_req = 1'b0; flush = 1'b0; done_du = 1'b0; busy_du = 1'b0; wb_ack = 1'b0;
        @(negedge CLK);
        check({tag, "_stall"}, 32'(stall), 32'(0));
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'(0));
        check({tag, "_err"}, 32'(err_timeout), 32'(pending_err));
        pending_err = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //           a             b   rem sgn rd  lat fl ack rr  rw hw  wf  wl idle err data
        tbl[0]  = mk(32'd100,      7,  0,  0,  5,  10, 0, 2,  5,  1, 1, 12, 14, 15, 0, 32'd14);
        tbl[1]  = mk(32'd100,      7,  0,  0,  5,  10, 4, 0,  5,  1, 0,  0,  0, 12, 0, 32'd0);
        tbl[2]  = mk(32'd50,       5,  0,  0,  6,   6, 7, 0,  6,  1, 0,  0,  0,  8, 0, 32'd0);
        tbl[3]  = mk(32'd9,        2,  0,  0,  7,   5, 0, 0,  0,  1, 0,  0,  0,  7, 0, 32'd0);
        tbl[4]  = mk(32'd9,        2,  0,  0,  7, 200, 0, 0,  7,  1, 0,  0,  0, 66, 1, 32'd0);
        tbl[5]  = mk(32'hFFFFFF9C, 7,  1,  1, 31,   1, 0, 0, 31,  1, 1,  3,  3,  4, 0, 32'hFFFFFFFE);
        tbl[6]  = mk(32'd8,        3,  0,  0,  2,   3, 1, 0,  2,  1, 0,  0,  0,  5, 0, 32'd0);
        tbl[7]  = mk(32'd81,       9,  0,  0,  4,   2, 6, 10, 4,  1, 1,  4,  6,  7, 0, 32'd9);
        tbl[8]  = mk(32'd1000,     3,  0,  0,  3,  64, 0, 0,  3,  1, 1, 66, 66, 67, 0, 32'd333);
        tbl[9]  = mk(32'd1000,     3,  0,  0,  3,  65, 0, 0,  3,  1, 0,  0,  0, 66, 1, 32'd0);
        tbl[10] = mk(32'd77,       7,  0,  0,  9,   3, 0, 0,  9,  0, 0,  0,  0,  5, 0, 32'd0);
        tbl[11] = mk(32'hFFFFFF9C, 7,  0,  1, 12,   4, 0, 1, 12,  1, 1,  6,  7,  8, 0, 32'hFFFFFFF2);
        tbl[12] = mk(32'd5,        1,  0,  0,  1, 200, 3, 0,  1,  1, 0,  0,  0, 68, 1, 32'd0);

        div_req = 1'b1; op_a = 32'hDEAD; op_b = 32'h1; op_rem = 1'b0; op_signed = 1'b0;
        op_rd = 5'd1; op_wen = 1'b1; flush = 1'b0; wdata_du = '0; busy_du = 1'b0;
        done_du = 1'b0; reg_rd_du = '0; wen_du = 1'b0; wb_ack = 1'b0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check("rst_div_ack", 32'(div_ack), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_start_div", 32'(start_div), 32'(0));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_err", 32'(err_timeout), 32'(0));
        check("rst_rs1_data", rs1_data, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(posedge CLK); #1;
        div_req = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;

        foreach (tbl[i]) run_vec(tbl[i]);
        idle_check("tbl_end");

        for (int n = 0; n < 150; n++) begin
            v.a = $urandom;
            v.b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if (v.b == 32'd0) v.b = 32'd1;
            v.rem = 1'($urandom); v.sgn = 1'($urandom); v.wen = 1'($urandom);
            if (v.sgn && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd2;
            v.rd = 5'($urandom);
            v.lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70))
                                                : int'($urandom_range(1, 15));
            v.fl = ($urandom_range(0, 5) < 3) ? 0 : int'($urandom_range(1, v.lat + 5));
            v.ackd = int'($urandom_range(0, 3));
            v.ret_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : v.rd;
            v.ret_wen = ($urandom_range(0, 7) != 0);
            v = model(v);
            run_vec(v);
        end
        idle_check("rnd_end");

        // Busy unit in IDLE: request must not be accepted
        div_req = 1'b1; busy_du = 1'b1;
        @(negedge CLK);
        check("busy_div_ack", 32'(div_ack), 32'(0));
        @(posedge CLK); #1;
        idle_check("busy_after");

        // Reset while a result is held for writeback
        div_req = 1'b1; op_a = 32'd55; op_b = 32'd5; op_rem = 1'b0; op_signed = 1'b0;
        op_rd = 5'd4; op_wen = 1'b1;
        @(negedge CLK);
        check("hr_div_ack", 32'(div_ack), 32'(1));
        @(posedge CLK); #1;
        div_req = 1'b0; busy_du = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        busy_du = 1'b0; done_du = 1'b1; wdata_du = 32'd11; reg_rd_du = 5'd4; wen_du = 1'b1;
        @(posedge CLK); #1;
        done_du = 1'b0;
        @(negedge CLK);
        check("hr_wb_valid", 32'(wb_valid), 32'(1));
        check("hr_wb_data", wb_data, 32'd11);
        #2 nRST = 1'b0;
        div_req = 1'b1;
        #1;
        check("hr_rst_wb_valid", 32'(wb_valid), 32'(0));
        check("hr_rst_stall", 32'(stall), 32'(0));
        check("hr_rst_div_ack", 32'(div_ack), 32'(0));
        check("hr_rst_wb_data", wb_data, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        div_req = 1'b0;
        pending_err = 1'b0;
        run_vec(tbl[0]);
        idle_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
